// File: rtl/cpu_run_monitor.sv
// Run controller and output monitor for the multi-cycle CPU: sequences CPU reset, counts run
// cycles, traces distinct output values and reports pass/fail on halt or timeout.
module cpu_run_monitor #(
  parameter int unsigned             DATA_W       = 32,
  parameter int unsigned             RESET_CYCLES = 4,
  parameter logic [DATA_W-1:0]       HALT_VALUE   = 32'hFFFF_FFFF,
  parameter int unsigned             HOLD_CYCLES  = 3,
  parameter int unsigned             TIMEOUT      = 4096,
  parameter int unsigned             CNT_W        = 16,
  parameter int unsigned             TRACE_DEPTH  = 16,
  parameter bit                      CHANGE_ONLY  = 1'b1,
  localparam int unsigned            AW           = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic [DATA_W-1:0] expect_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic              overflow,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [AW:0]       trace_count,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned HC_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StRst, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [HC_W-1:0]     halt_cnt_q, halt_cnt_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [AW:0]         tcount_q, tcount_d;
  logic                overflow_q, overflow_d;
  logic                pass_q, pass_d;
  logic                timed_out_q, timed_out_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic                trace_we;
  logic                record;
  logic [DATA_W-1:0]   trace_mem [TRACE_DEPTH];

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    halt_cnt_d  = halt_cnt_q;
    cycle_d     = cycle_q;
    tcount_d    = tcount_q;
    overflow_d  = overflow_q;
    pass_d      = pass_q;
    timed_out_d = timed_out_q;
    last_d      = last_q;
    trace_we    = 1'b0;
    record      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRst;
          rst_cnt_d   = '0;
          halt_cnt_d  = '0;
          cycle_d     = '0;
          tcount_d    = '0;
          overflow_d  = 1'b0;
          pass_d      = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      StRst: begin
        if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (cycle_q != CNT_W'(TIMEOUT)) begin
          cycle_d = cycle_q + 1'b1;
        end
        // cycle_q == 0 marks the first RUN cycle, which always records.
        record = (cycle_q == '0) || !CHANGE_ONLY || (cpu_out != last_q);
        if (record) begin
          if (tcount_q < (AW + 1)'(TRACE_DEPTH)) begin
            trace_we = 1'b1;
            tcount_d = tcount_q + 1'b1;
            last_d   = cpu_out;
          end else begin
            overflow_d = 1'b1;
          end
        end
        halt_cnt_d = (cpu_out == HALT_VALUE) ? halt_cnt_q + 1'b1 : '0;
        if (halt_cnt_d == HC_W'(HOLD_CYCLES)) begin
          state_d     = StDone;
          pass_d      = (cpu_out == expect_data) && !overflow_d;
          timed_out_d = 1'b0;
        end else if (cycle_d == CNT_W'(TIMEOUT)) begin
          state_d     = StDone;
          pass_d      = 1'b0;
          timed_out_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      halt_cnt_q  <= '0;
      cycle_q     <= '0;
      tcount_q    <= '0;
      overflow_q  <= 1'b0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      halt_cnt_q  <= halt_cnt_d;
      cycle_q     <= cycle_d;
      tcount_q    <= tcount_d;
      overflow_q  <= overflow_d;
      pass_q      <= pass_d;
      timed_out_q <= timed_out_d;
      last_q      <= last_d;
    end
  end

  // Trace storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (trace_we) begin
      trace_mem[tcount_q[AW-1:0]] <= cpu_out;
    end
  end

  assign cpu_reset   = (state_q != StRun);
  assign busy        = (state_q == StRst) || (state_q == StRun);
  assign done        = (state_q == StDone);
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign overflow    = overflow_q;
  assign cycle_count = cycle_q;
  assign trace_count = tcount_q;
  assign rd_data     = trace_mem[rd_addr];

endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run controller and output monitor for the multi-cycle CPU; the parametrised, self-checking successor to the hand-driven CPU testbench. It sequences the CPU's reset, counts run cycles, and records every distinct value on the CPU `out` bus into a trace buffer. It ends the run on a halt pattern or a timeout, then reports pass/fail against an expected final value. It sits between the board or simulation top and `MultiCycleCPU`, driving the CPU's `reset` and observing its `out`.

## Interface
- DATA_W, 32, width of the CPU output bus
- RESET_CYCLES, 4, cycles `cpu_reset` is held high after `start` (≥1)
- HALT_VALUE, 32'hFFFF_FFFF, `cpu_out` value that signals program end
- HOLD_CYCLES, 3, consecutive cycles at HALT_VALUE required to end the run (≥1)
- TIMEOUT, 4096, maximum RUN cycles (≥2, < 2^CNT_W)
- CNT_W, 16, width of `cycle_count`
- TRACE_DEPTH, 16, trace buffer entries (power of 2)
- CHANGE_ONLY, 1, 1 = record only when `cpu_out` differs from the last recorded value; 0 = record every RUN cycle
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; sampled in IDLE and DONE only
- cpu_out  in  DATA_W  CPU `out` bus
- expect_data  in  DATA_W  expected final value; sampled on the cycle the run ends
- cpu_reset  out  1  drives CPU `reset`
- busy  out  1  high in RST and RUN
- done  out  1  high in DONE
- pass  out  1  valid while `done`
- timed_out  out  1  valid while `done`
- overflow  out  1  trace buffer filled and a record was dropped
- cycle_count  out  CNT_W  RUN cycles elapsed
- trace_count  out  $clog2(TRACE_DEPTH)+1  entries written
- rd_addr  in  $clog2(TRACE_DEPTH)  trace read address
- rd_data  out  DATA_W  trace[rd_addr], combinational read

## Operation
- States: IDLE → RST → RUN → DONE; DONE → RST on `start`.
- Reset values:
  - State IDLE.
  - `cpu_reset`=1.
  - `busy`, `done`, `pass`, `timed_out`, `overflow` = 0.
  - `cycle_count` = 0, `trace_count` = 0.
  - Trace contents are not cleared.
- IDLE: `cpu_reset`=1. `start` moves to RST and clears `cycle_count`, `trace_count`, `overflow`, `pass`, `timed_out`, and the halt-run counter.
- RST: `cpu_reset`=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN: `cpu_reset`=0. Each cycle:
  - `cycle_count` increments (saturates at TIMEOUT).
  - Record condition: first RUN cycle, OR CHANGE_ONLY=0, OR `cpu_out` ≠ last recorded value.
  - On record: if `trace_count` < TRACE_DEPTH, write trace[trace_count] ← `cpu_out` and increment `trace_count`; else set `overflow` (sticky) and drop the record.
  - Halt-run counter increments while `cpu_out`==HALT_VALUE and clears otherwise.
- Run end:
  - Halt: the halt-run counter reaches HOLD_CYCLES. Go to DONE; `pass` ← (`cpu_out`==`expect_data`) & ~`overflow`; `timed_out`=0.
  - Timeout: `cycle_count` reaches TIMEOUT without a halt. Go to DONE; `timed_out`=1, `pass`=0.
  - Halt and timeout on the same cycle: halt wins.
- DONE: `cpu_reset`=1 (CPU frozen), `done`=1. Flags, count, and trace hold until `start` or `reset`.
- `start` in RST or RUN is ignored.
- `reset` in any state returns to reset values on the next edge; `cpu_reset` is 1 from that edge.
- `rd_data` is defined only for `rd_addr` < `trace_count`; other addresses return stale content.

## Timing
- `start` at edge N → RST from N+1. `cpu_reset` is high N+1..N+RESET_CYCLES and first low at N+RESET_CYCLES+1 (first RUN cycle).
- Trace writes, counters, and flags update at the edge closing the RUN cycle being sampled. They are visible the following cycle.
- A halt detected in RUN cycle k puts `done`=1 in cycle k+1. `cycle_count` then equals k (RUN cycles numbered from 1).
- Halt latency: HOLD_CYCLES cycles at HALT_VALUE, plus 1, to `done`.
- `rd_data` reflects a write one cycle after the write edge.

## Test plan
- Defaults. `cpu_out` steps 0,0,5,5,9 then holds HALT_VALUE; `expect_data`=HALT_VALUE → trace = {0,5,9,FFFF_FFFF}, `trace_count`=4, `done` and `pass`=1, `cycle_count`=8, `cpu_reset` low exactly during RUN.
- Same stimulus, `expect_data`=7 → `done`=1, `pass`=0, `timed_out`=0.
- `cpu_out` never reaches HALT_VALUE, TIMEOUT=20 → `done` after 20 RUN cycles, `timed_out`=1, `pass`=0, `cycle_count`=20.
- CHANGE_ONLY=0, TRACE_DEPTH=4, halt after 6 cycles → `trace_count`=4, `overflow`=1, `pass`=0 despite the match.
- `reset` pulsed in RUN cycle 3 → next cycle IDLE, `cpu_reset`=1, all flags and counts 0. A `start` pulse mid-run (no reset) is ignored, with `cycle_count` continuing.
- HALT_VALUE held 2 cycles, broken, then held 3 (HOLD_CYCLES=3) → halts only after the third consecutive cycle. Restart from DONE via `start` clears the flags and reruns.
